upstream_order_arbiter: RTL
===========================

# upstream_order_arbiter

Shares the single upstream risk-check datapath (the direct-mapped client cache plus the signed risk comparison) between N order sources. Grants one requester at a time in round-robin order and sequences cache read, risk check, conditional write-back and response, with a timeout on the cache handshake. Sits between the order-entry ports and `dm_cache_fsm_upstream`, replacing ad-hoc direct drive of the cache request from the order path.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: maximum cycles to wait for `cache_res_ready` per cache access.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  order request per port.
- `req_ready`  out  N_REQ  one-hot grant pulse, accepts that port's request.
- `req_client`  in  N_REQ*9  client id per port, port p at [9p+8:9p].
- `req_amount`  in  N_REQ*16  order amount, or new max when `req_new_max`.
- `req_cancelled`  in  N_REQ*16  cancelled quantity for the client.
- `req_new_max`  in  N_REQ  request is a max-to-trade update, not an order.
- `cache_req_valid`  out  1  cache request valid.
- `cache_req_rw`  out  1  0 = read, 1 = write.
- `cache_req_index`  out  32  {19'b0, client[8:0], 4'b0}.
- `cache_req_data`  out  32  write data {max[15:0], accumulated[15:0]}.
- `cache_res_ready`  in  1  cache access complete.
- `cache_res_data`  in  32  read data {max, accumulated}.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumed.
- `resp_port`  out  3  port index of the response.
- `resp_pass`  out  1  order passed the risk check (1 for a successful new-max request).
- `resp_err`  out  1  cache timeout; no write performed.
- `resp_accum`  out  16  accumulated value after the operation, or the read value if rejected.

## Operation
- States: IDLE, READ, CHECK, WRITE, RESP.
- IDLE: if any `req_valid`, grant the first valid port strictly after `last_grant` (wrapping), pulse its `req_ready` for 1 cycle, latch client/amount/cancelled/new_max, set `last_grant`, go to READ.
- READ: `cache_req_valid`=1, rw=0 until `cache_res_ready`. Latch max=data[31:16] and acc=data[15:0], go to CHECK.
- CHECK (1 cycle): result = acc − cancelled + amount, computed in 18-bit signed (operands zero-extended). pass = $signed({2'b0,max}) > result.
  - new_max: pass=1, wdata={amount, acc}.
  - order with pass: wdata={max, result[15:0]}.
  - pass=1 goes to WRITE; pass=0 goes to RESP with accum=acc.
- WRITE: `cache_req_valid`=1, rw=1, data=wdata until `cache_res_ready`, then RESP with accum=wdata[15:0].
- RESP: `resp_valid` held with stable fields until `resp_ready`, then IDLE. No new grant while not IDLE.
- Timeout: a counter is cleared on entering READ or WRITE. If it reaches TIMEOUT without `cache_res_ready`: drop `cache_req_valid`, go to RESP with err=1, pass=0, accum=0.
- Cache request fields are stable while `cache_req_valid`=1. `req_ready` is never asserted to a port whose `req_valid`=0.

## Timing
- Reset: all outputs 0, state IDLE, `last_grant`=N_REQ−1 (port 0 wins first), counter 0. Reset in any state aborts the operation; no response is issued for it.
- Grant at cycle T; `cache_req_valid` from T+1. With zero-wait cache (ready in same cycle as valid): read completes T+1, CHECK T+2, write T+3, `resp_valid` T+4. Rejected order: `resp_valid` T+3.
- `resp_ready` high in the first RESP cycle lets the next grant occur the following cycle (IDLE 1 cycle).
- `cache_res_ready` outside READ/WRITE is ignored.
- Single active request: re-granted every transaction. All ports valid: grant order 0,1,2,3,0…

## Structure
- Package `upstream_arb_pkg`: state enum, response struct, MAX/ACC field position constants, 18-bit result width constant.
- Sub-module `rr_arbiter` (N_REQ-parameterised): inputs valid vector, last_grant, enable; outputs one-hot grant and encoded index.

## Test plan
- Port 0 only, client 5, max 100, acc 40, cancelled 10, amount 30 → result 60, pass=1, write {100,60}, resp accum=60 at T+4.
- Same client, amount 80 (result 110 ≥ 100) → pass=0, no write, resp accum=40 at T+3.
- Ports 0–3 valid continuously, zero-wait cache → grants 0,1,2,3,0, each `req_ready` a single-cycle one-hot pulse.
- new_max on port 2, amount 500, acc 40 → write {500,40}, pass=1.
- `cache_res_ready` held low during READ → after 64 cycles resp_err=1, no write.
- `rst` asserted in WRITE → next cycle all outputs 0, IDLE; port 0 is granted first afterwards.

Source files
------------

// File: rtl/upstream_order_arbiter_pkg.sv
// Shared types and field positions for the upstream order arbiter.
package upstream_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0]  port;
        logic        pass;
        logic        err;
        logic [15:0] accum;
    } resp_t;

    localparam int MAX_MSB = 31;
    localparam int MAX_LSB = 16;
    localparam int ACC_MSB = 15;
    localparam int ACC_LSB = 0;
    localparam int RES_W   = 18;

endpackage

// File: rtl/upstream_order_arbiter_if.sv
// Cache request/response channel between the arbiter (master) and dm_cache_fsm_upstream (slave).
interface upstream_order_arbiter_if;
    logic        cache_req_valid;
    logic        cache_req_rw;
    logic [31:0] cache_req_index;
    logic [31:0] cache_req_data;
    logic        cache_res_ready;
    logic [31:0] cache_res_data;

    modport master (
        output cache_req_valid, cache_req_rw, cache_req_index, cache_req_data,
        input  cache_res_ready, cache_res_data
    );

    modport slave (
        input  cache_req_valid, cache_req_rw, cache_req_index, cache_req_data,
        output cache_res_ready, cache_res_data
    );
endinterface

// File: rtl/upstream_order_arbiter_rr.sv
// Round-robin pick: first valid port strictly after last_grant, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [2:0]       last_grant_i,
    input  logic             enable_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [2:0]       idx_o
);
    always_comb begin
        int   p;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        p       = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            p = (int'(last_grant_i) + off) % N_REQ;
            if (enable_i && !found && valid_i[p]) begin
                grant_o[p] = 1'b1;
                idx_o      = 3'(p);
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/upstream_order_arbiter.sv
// Shares the cache + risk-check datapath among N_REQ order ports.
// States: IDLE grant | READ cache read | CHECK risk compare | WRITE write-back | RESP hold response
module upstream_order_arbiter
    import upstream_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*9-1:0]    req_client_i,
    input  logic [N_REQ*16-1:0]   req_amount_i,
    input  logic [N_REQ*16-1:0]   req_cancelled_i,
    input  logic [N_REQ-1:0]      req_new_max_i,
    upstream_order_arbiter_if.master cache,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [2:0]            resp_port_o,
    output logic                  resp_pass_o,
    output logic                  resp_err_o,
    output logic [15:0]           resp_accum_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [2:0]       last_grant_q, last_grant_d;
    logic [8:0]       client_q, client_d;
    logic [15:0]      amount_q, amount_d;
    logic [15:0]      cancel_q, cancel_d;
    logic             newmax_q, newmax_d;
    logic [15:0]      max_q, max_d;
    logic [15:0]      acc_q, acc_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    resp_t            resp_q, resp_d;

    logic [N_REQ-1:0]        grant;
    logic [2:0]              gnt_idx;
    logic signed [RES_W-1:0] result;
    logic                    pass;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid_i      (req_valid_i),
        .last_grant_i (last_grant_q),
        .enable_i     ((state_q == S_IDLE) && !rst),
        .grant_o      (grant),
        .idx_o        (gnt_idx)
    );

    // Operands are zero-extended so the 18-bit signed result covers both underflow and carry.
    assign result = $signed({2'b00, acc_q}) - $signed({2'b00, cancel_q})
                  + $signed({2'b00, amount_q});
    assign pass   = $signed({2'b00, max_q}) > result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 3'(N_REQ - 1);
            client_q     <= '0;
            amount_q     <= '0;
            cancel_q     <= '0;
            newmax_q     <= 1'b0;
            max_q        <= '0;
            acc_q        <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            client_q     <= client_d;
            amount_q     <= amount_d;
            cancel_q     <= cancel_d;
            newmax_q     <= newmax_d;
            max_q        <= max_d;
            acc_q        <= acc_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        client_d     = client_q;
        amount_d     = amount_q;
        cancel_d     = cancel_q;
        newmax_d     = newmax_q;
        max_d        = max_q;
        acc_d        = acc_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    client_d     = req_client_i[int'(gnt_idx)*9 +: 9];
                    amount_d     = req_amount_i[int'(gnt_idx)*16 +: 16];
                    cancel_d     = req_cancelled_i[int'(gnt_idx)*16 +: 16];
                    newmax_d     = req_new_max_i[gnt_idx];
                    last_grant_d = gnt_idx;
                    resp_d.port  = gnt_idx;
                    cnt_d        = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                if (cache.cache_res_ready) begin
                    max_d   = cache.cache_res_data[MAX_MSB:MAX_LSB];
                    acc_d   = cache.cache_res_data[ACC_MSB:ACC_LSB];
                    state_d = S_CHECK;
                end else if (cnt_q == CNT_LAST) begin
                    resp_d.pass  = 1'b0;
                    resp_d.err   = 1'b1;
                    resp_d.accum = '0;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (newmax_q) begin
                    wdata_d = {amount_q, acc_q};
                    state_d = S_WRITE;
                end else if (pass) begin
                    wdata_d = {max_q, result[15:0]};
                    state_d = S_WRITE;
                end else begin
                    resp_d.pass  = 1'b0;
                    resp_d.err   = 1'b0;
                    resp_d.accum = acc_q;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                if (cache.cache_res_ready) begin
                    resp_d.pass  = 1'b1;
                    resp_d.err   = 1'b0;
                    resp_d.accum = wdata_q[ACC_MSB:ACC_LSB];
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_d.pass  = 1'b0;
                    resp_d.err   = 1'b1;
                    resp_d.accum = '0;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o           = grant;
    assign cache.cache_req_valid = (state_q == S_READ) || (state_q == S_WRITE);
    assign cache.cache_req_rw    = (state_q == S_WRITE);
    assign cache.cache_req_index = {19'b0, client_q, 4'b0};
    assign cache.cache_req_data  = (state_q == S_WRITE) ? wdata_q : 32'h0;

    assign resp_valid_o = (state_q == S_RESP);
    assign resp_port_o  = resp_q.port;
    assign resp_pass_o  = resp_q.pass;
    assign resp_err_o   = resp_q.err;
    assign resp_accum_o = resp_q.accum;
endmodule
